pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Consumer side of the hazard protocol: takes load-use stall, branch/jump redirect and data-memory busy
//  requests and drives PC/IF-ID write enables and per-stage flush controls of the 5-stage MIPS pipeline.
//  Sits between the hazard detectors (ID/EX) and the pipeline registers. Also tracks freeze timeout,
//  checks the one-cycle load-use protocol and keeps saturating stall/flush performance counters.
// PARAMETERS
//  CNT_W     16  width of each performance counter (saturating)
//  MAX_WAIT  64  consecutive dmem_busy_i cycles before timeout_o sets (range 2..2**CNT_W-1)
// PORTS
//  clk_i            in   1      clock, all state on rising edge
//  rst_i            in   1      synchronous reset, active low
//  lw_stall_i       in   1      load-use stall request from ID-stage detector
//  branch_taken_i   in   1      taken branch resolved in EX: redirect, kill IF/ID and ID/EX
//  jump_i           in   1      jump decoded in ID: redirect, kill IF/ID only
//  dmem_busy_i      in   1      data memory not ready: freeze entire pipeline
//  pc_write_o       out  1      PC register write enable
//  if_id_write_o    out  1      IF/ID register write enable
//  if_id_flush_o    out  1      IF/ID register -> NOP
//  id_ex_flush_o    out  1      ID/EX control -> zero (bubble)
//  ex_mem_write_o   out  1      EX/MEM and MEM/WB write enable
//  stall_cnt_o      out  CNT_W  load-use bubbles inserted
//  flush_cnt_o      out  CNT_W  redirect events (branch + jump)
//  freeze_cnt_o     out  CNT_W  cycles frozen by dmem_busy_i
//  timeout_o        out  1      sticky: dmem_busy_i held MAX_WAIT consecutive cycles
//  protocol_err_o   out  1      sticky: lw_stall_i asserted on the cycle right after a bubble
// BEHAVIOUR
//  - Control outputs are combinational from current inputs + state (zero latency); counters/flags are registered.
//  - While rst_i==0: pc_write_o=if_id_write_o=ex_mem_write_o=0, all flush outputs 0; on the edge: state=RUN,
//    counters=0, timeout_o=0, protocol_err_o=0, bubble_q=0, wait_cnt=0. First cycle after release is normal RUN.
//  - Priority per cycle: dmem_busy_i > branch_taken_i > lw_stall_i > jump_i > none.
//    FREEZE : all write enables 0, all flushes 0 (lower requests ignored, must be re-presented by held regs).
//    BRANCH : all writes 1, if_id_flush_o=1, id_ex_flush_o=1.
//    LWSTALL: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, ex_mem_write_o=1, if_id_flush_o=0.
//    JUMP   : all writes 1, if_id_flush_o=1.
//    none   : all writes 1, flushes 0.
//  - FSM: RUN -> FRZ when dmem_busy_i=1; FRZ -> RUN when dmem_busy_i=0 (that cycle is evaluated as RUN priority).
//    wait_cnt counts consecutive FRZ cycles; at wait_cnt==MAX_WAIT set timeout_o (stays until reset);
//    wait_cnt clears on leaving FRZ and saturates at MAX_WAIT.
//  - bubble_q <= 1 in a cycle where LWSTALL was applied, else 0 (held unchanged during FREEZE). lw_stall_i=1
//    with bubble_q=1 and no higher-priority request: set protocol_err_o, still apply LWSTALL.
//  - Counters saturate at 2**CNT_W-1: stall_cnt +1 per LWSTALL cycle, flush_cnt +1 per BRANCH or JUMP cycle,
//    freeze_cnt +1 per FREEZE cycle. Exactly one counter increments per cycle at most.
//  - Simultaneous branch+jump: branch wins (jump is on wrong path). Simultaneous branch+lw_stall: branch wins,
//    no stall counted. Reset mid-freeze: freeze aborted, outputs follow reset values immediately.
// STRUCTURE
//  - hazard_pkg: state enum {RUN, FRZ}; action enum {ACT_NONE, ACT_JUMP, ACT_LW, ACT_BRANCH, ACT_FREEZE};
//    ctrl struct {pc_we, ifid_we, ifid_fl, idex_fl, exmem_we} and constant table action->ctrl.
//  - Sub-module sat_counter #(W) (clk_i, rst_i, inc_i, cnt_o): instantiated three times for perf counters.
//  - Top: priority encoder -> action, FSM + wait_cnt, bubble_q, sticky flags, output table lookup.
// TESTING
//  1 Reset held 3 cycles, release, no requests -> during reset all enables 0; after: writes=1, flushes=0, counters 0.
//  2 lw_stall_i pulse 1 cycle -> pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1 that cycle; stall_cnt_o=1 next;
//    lw_stall_i 2 consecutive cycles -> protocol_err_o=1 from cycle 3, sticky.
//  3 branch_taken_i+jump_i+lw_stall_i same cycle -> if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1;
//    flush_cnt_o=1, stall_cnt_o=0.
//  4 MAX_WAIT=4, dmem_busy_i 4 cycles -> all enables 0 each cycle, timeout_o=1 after 4th; freeze_cnt_o=4;
//    busy 3 cycles -> timeout_o stays 0.
//  5 CNT_W=2, 5 jumps -> flush_cnt_o saturates at 3; rst_i low mid-freeze -> next cycle counters 0, state RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and action-to-control table for the hazard controller.
// Revision    : 1.0
// ============================================================================
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        FRZ = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_JUMP   = 3'd1,
        ACT_LW     = 3'd2,
        ACT_BRANCH = 3'd3,
        ACT_FREEZE = 3'd4
    } action_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_fl;
        logic idex_fl;
        logic exmem_we;
    } ctrl_t;

    localparam ctrl_t c_CTRL_NONE   = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_fl: 1'b0, idex_fl: 1'b0, exmem_we: 1'b1};
    localparam ctrl_t c_CTRL_JUMP   = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_fl: 1'b1, idex_fl: 1'b0, exmem_we: 1'b1};
    localparam ctrl_t c_CTRL_LW     = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_fl: 1'b0, idex_fl: 1'b1, exmem_we: 1'b1};
    localparam ctrl_t c_CTRL_BRANCH = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_fl: 1'b1, idex_fl: 1'b1, exmem_we: 1'b1};
    localparam ctrl_t c_CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_fl: 1'b0, idex_fl: 1'b0, exmem_we: 1'b0};

    function automatic ctrl_t act_to_ctrl(input action_t act);
        ctrl_t ctrl;
        case (act)
            ACT_JUMP:   ctrl = c_CTRL_JUMP;
            ACT_LW:     ctrl = c_CTRL_LW;
            ACT_BRANCH: ctrl = c_CTRL_BRANCH;
            ACT_FREEZE: ctrl = c_CTRL_FREEZE;
            default:    ctrl = c_CTRL_NONE;
        endcase
        return ctrl;
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Turns stall/redirect/freeze requests into pipeline enables and
//               flushes; tracks freeze timeout, load-use protocol, perf counters.
// Revision    : 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lw_stall_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_busy_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o,
    output logic             timeout_o,
    output logic             protocol_err_o
);

    localparam int                  c_WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

    state_t              r_state;
    state_t              w_state_nxt;
    action_t             w_act;
    ctrl_t               w_ctrl;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                r_bubble;
    logic                r_timeout;
    logic                r_proto_err;

    // Fixed priority: freeze > branch > load-use > jump.
    always_comb begin
        w_act = ACT_NONE;
        if (dmem_busy_i) begin
            w_act = ACT_FREEZE;
        end else if (branch_taken_i) begin
            w_act = ACT_BRANCH;
        end else if (lw_stall_i) begin
            w_act = ACT_LW;
        end else if (jump_i) begin
            w_act = ACT_JUMP;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            RUN:     if (dmem_busy_i)  w_state_nxt = FRZ;
            FRZ:     if (!dmem_busy_i) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
        if (!dmem_busy_i) begin
            w_wait_nxt = '0;
        end else if (r_wait_cnt != c_WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_bubble    <= 1'b0;
            r_timeout   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == c_WAIT_MAX) begin
                r_timeout <= 1'b1;
            end
            // Bubble history survives a freeze so a held load-use request is still judged correctly.
            if (w_act != ACT_FREEZE) begin
                r_bubble <= (w_act == ACT_LW);
            end
            if ((w_act == ACT_LW) && r_bubble) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign w_ctrl = rst_i ? act_to_ctrl(w_act) : '0;

    assign pc_write_o     = w_ctrl.pc_we;
    assign if_id_write_o  = w_ctrl.ifid_we;
    assign if_id_flush_o  = w_ctrl.ifid_fl;
    assign id_ex_flush_o  = w_ctrl.idex_fl;
    assign ex_mem_write_o = w_ctrl.exmem_we;
    assign timeout_o      = r_timeout;
    assign protocol_err_o = r_proto_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_act == ACT_LW),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i ((w_act == ACT_BRANCH) || (w_act == ACT_JUMP)),
        .cnt_o (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_act == ACT_FREEZE),
        .cnt_o (freeze_cnt_o)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lw, br, jmp, busy;
    logic        pc_we, ifid_we, ifid_fl, idex_fl, exmem_we;
    logic [15:0] stall_cnt, flush_cnt, freeze_cnt;
    logic        timeout, perr;
    logic        s_pc_we, s_ifid_we, s_ifid_fl, s_idex_fl, s_exmem_we;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_freeze_cnt;
    logic        s_timeout, s_perr;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.CNT_W(16), .MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_i(rst_n), .lw_stall_i(lw), .branch_taken_i(br), .jump_i(jmp),
        .dmem_busy_i(busy), .pc_write_o(pc_we), .if_id_write_o(ifid_we), .if_id_flush_o(ifid_fl),
        .id_ex_flush_o(idex_fl), .ex_mem_write_o(exmem_we), .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt), .freeze_cnt_o(freeze_cnt), .timeout_o(timeout),
        .protocol_err_o(perr)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .MAX_WAIT(4)) dut_s (
        .clk_i(clk), .rst_i(rst_n), .lw_stall_i(lw), .branch_taken_i(br), .jump_i(jmp),
        .dmem_busy_i(busy), .pc_write_o(s_pc_we), .if_id_write_o(s_ifid_we), .if_id_flush_o(s_ifid_fl),
        .id_ex_flush_o(s_idex_fl), .ex_mem_write_o(s_exmem_we), .stall_cnt_o(s_stall_cnt),
        .flush_cnt_o(s_flush_cnt), .freeze_cnt_o(s_freeze_cnt), .timeout_o(s_timeout),
        .protocol_err_o(s_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle packed as {pc_we, ifid_we, ifid_fl, idex_fl, exmem_we}.
    function automatic logic [4:0] ctl();
        return {pc_we, ifid_we, ifid_fl, idex_fl, exmem_we};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lw = 1'b0; br = 1'b0; jmp = 1'b0; busy = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl() !== 5'b00000) begin
                errors++;
                $display("FAIL reset_ctl[%0d]: got %b expected 00000", i, ctl());
            end
            step();
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b11001) begin
            errors++;
            $display("FAIL post_reset_ctl: got %b expected 11001", ctl());
        end
        checks++;
        if ({stall_cnt, flush_cnt, freeze_cnt, timeout, perr} !== 50'd0) begin
            errors++;
            $display("FAIL post_reset_state: got stall=%0d flush=%0d freeze=%0d to=%b perr=%b expected all 0",
                     stall_cnt, flush_cnt, freeze_cnt, timeout, perr);
        end
    endtask

    task automatic test_lw_stall();
        apply_reset();
        lw = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b00011) begin
            errors++;
            $display("FAIL lw_ctl: got %b expected 00011", ctl());
        end
        step();
        lw = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'd1 || perr !== 1'b0) begin
            errors++;
            $display("FAIL lw_count: got stall=%0d perr=%b expected stall=1 perr=0", stall_cnt, perr);
        end
        step();
        lw = 1'b1;
        step();
        #1;
        checks++;
        if (ctl() !== 5'b00011 || perr !== 1'b0) begin
            errors++;
            $display("FAIL lw_second_cycle: got ctl=%b perr=%b expected ctl=00011 perr=0", ctl(), perr);
        end
        step();
        lw = 1'b0;
        #1;
        checks++;
        if (perr !== 1'b1 || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL lw_protocol: got perr=%b stall=%0d expected perr=1 stall=3", perr, stall_cnt);
        end
        step();
        step();
        checks++;
        if (perr !== 1'b1) begin
            errors++;
            $display("FAIL lw_perr_sticky: got %b expected 1", perr);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        br = 1'b1; jmp = 1'b1; lw = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b11111) begin
            errors++;
            $display("FAIL prio_ctl: got %b expected 11111", ctl());
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL prio_counts: got flush=%0d stall=%0d expected flush=1 stall=0", flush_cnt, stall_cnt);
        end
        lw = 1'b1; jmp = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b00011) begin
            errors++;
            $display("FAIL lw_over_jump: got %b expected 00011", ctl());
        end
        lw = 1'b0;
        #1;
        checks++;
        if (ctl() !== 5'b11101) begin
            errors++;
            $display("FAIL jump_ctl: got %b expected 11101", ctl());
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (flush_cnt !== 16'd2 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL jump_count: got flush=%0d stall=%0d expected flush=2 stall=0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_freeze();
        apply_reset();
        busy = 1'b1; br = 1'b1; lw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl() !== 5'b00000) begin
                errors++;
                $display("FAIL freeze_ctl[%0d]: got %b expected 00000", i, ctl());
            end
            step();
            checks++;
            if (timeout !== (i == 3)) begin
                errors++;
                $display("FAIL freeze_timeout[%0d]: got %b expected %b", i, timeout, (i == 3));
            end
        end
        clear_inputs();
        #1;
        checks++;
        if (freeze_cnt !== 16'd4 || flush_cnt !== 16'd0 || stall_cnt !== 16'd0 || ctl() !== 5'b11001) begin
            errors++;
            $display("FAIL freeze_exit: got freeze=%0d flush=%0d stall=%0d ctl=%b expected 4 0 0 11001",
                     freeze_cnt, flush_cnt, stall_cnt, ctl());
        end
        apply_reset();
        busy = 1'b1;
        repeat (3) step();
        busy = 1'b0;
        step();
        busy = 1'b1;
        repeat (3) step();
        busy = 1'b0;
        step();
        checks++;
        if (timeout !== 1'b0 || freeze_cnt !== 16'd6) begin
            errors++;
            $display("FAIL freeze_short: got to=%b freeze=%0d expected to=0 freeze=6", timeout, freeze_cnt);
        end
    endtask

    task automatic test_saturate_and_reset();
        apply_reset();
        jmp = 1'b1;
        repeat (5) step();
        jmp = 1'b0;
        #1;
        checks++;
        if (s_flush_cnt !== 2'd3 || flush_cnt !== 16'd5) begin
            errors++;
            $display("FAIL flush_saturate: got narrow=%0d wide=%0d expected narrow=3 wide=5", s_flush_cnt, flush_cnt);
        end
        busy = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl() !== 5'b00000 || freeze_cnt !== 16'd2) begin
            errors++;
            $display("FAIL reset_midfreeze_ctl: got ctl=%b freeze=%0d expected ctl=00000 freeze=2", ctl(), freeze_cnt);
        end
        step();
        rst_n = 1'b1;
        busy = 1'b0;
        #1;
        checks++;
        if (freeze_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_flush_cnt !== 2'd0 || timeout !== 1'b0
            || ctl() !== 5'b11001) begin
            errors++;
            $display("FAIL reset_midfreeze_state: got freeze=%0d flush=%0d sflush=%0d to=%b ctl=%b expected 0 0 0 0 11001",
                     freeze_cnt, flush_cnt, s_flush_cnt, timeout, ctl());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        br = 1'b1;
        step();
        br = 1'b0; jmp = 1'b1;
        step();
        jmp = 1'b0; lw = 1'b1;
        step();
        lw = 1'b0; busy = 1'b1;
        step();
        busy = 1'b0; lw = 1'b1;
        #1;
        checks++;
        if (perr !== 1'b0 || ctl() !== 5'b00011) begin
            errors++;
            $display("FAIL b2b_lw_after_freeze: got perr=%b ctl=%b expected perr=0 ctl=00011", perr, ctl());
        end
        step();
        lw = 1'b0;
        #1;
        checks++;
        if (perr !== 1'b1 || flush_cnt !== 16'd2 || stall_cnt !== 16'd2 || freeze_cnt !== 16'd1) begin
            errors++;
            $display("FAIL b2b_counts: got perr=%b flush=%0d stall=%0d freeze=%0d expected 1 2 2 1",
                     perr, flush_cnt, stall_cnt, freeze_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_priority();
        test_freeze();
        test_saturate_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
